uart_rx_core: RTL
=================

// Module: uart_rx_core
// PURPOSE
//  UART receiver: the receive end of the UART TX frame (start, 8 data LSB-first, optional parity, stop).
//  Oversamples RX_IN by PRESCALE CLK cycles per bit and majority-votes the 3 centre samples.
//  Delivers parallel byte plus parity/stop error flags. Sits behind the DFT clock/reset muxes like UART_TX.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame
// PORTS
//  CLK         in   1           oversampling clock, one tick per CLK
//  RST         in   1           async reset, active-low
//  RX_IN       in   1           serial line, idle high, asynchronous to CLK
//  PRESCALE    in   6           oversample ratio; legal values are 8, 16 and 32
//  PAR_EN      in   1           1 = frame carries a parity bit
//  PAR_TYP     in   1           0 = even, 1 = odd
//  P_DATA      out  DATA_WIDTH  received byte, bit 0 = first data bit on the line
//  DATA_VALID  out  1           1-cycle pulse, error-free frame, P_DATA valid
//  PAR_ERR     out  1           1-cycle pulse, parity mismatch
//  STP_ERR     out  1           1-cycle pulse, stop bit sampled low
// BEHAVIOUR
//  Reset values: P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0. State=IDLE, counters=0, sync flops=1.
//  Reset mid-frame aborts the frame and produces no output pulse.
//  RX_IN passes a 2-flop synchronizer (rx_s). All timing below refers to rx_s.
//  edge_cnt counts 0..PRESCALE-1 within a bit. bit_cnt counts the data bits.
//  Samples are taken at edge_cnt = P/2-1, P/2 and P/2+1. Bit value = majority of the 3 samples.
//  PRESCALE, PAR_EN and PAR_TYP are latched on the IDLE->START transition and held for the whole frame.
//  An illegal PRESCALE latches as 8.
//  FSM:
//   IDLE:   rx_s==0 -> START, edge_cnt=0.
//   START:  majority==1 at P/2+1 -> IDLE (glitch, no output). Otherwise at edge_cnt=P-1 -> DATA.
//   DATA:   at P/2+1 shift the voted bit in LSB-first. After bit DATA_WIDTH-1 ends (edge_cnt=P-1):
//           -> PARITY if PAR_EN, else -> STOP.
//   PARITY: expected = ^data ^ PAR_TYP. The voted bit is compared; a mismatch sets the internal par_fail flag.
//           At edge_cnt=P-1 -> STOP.
//   STOP:   at P/2+1 evaluate and return to IDLE in the same cycle. Rx can re-arm during the second half of stop.
//  Evaluation (registered, outputs visible 1 cycle after the stop P/2+1 tick):
//   stop voted 0          -> STP_ERR=1; PAR_ERR=par_fail; DATA_VALID=0; P_DATA unchanged.
//   stop ok, par_fail     -> PAR_ERR=1; DATA_VALID=0; P_DATA unchanged.
//   stop ok, parity ok    -> P_DATA=byte; DATA_VALID=1.
//   All pulses are exactly one cycle wide. Only the outputs listed above change.
//  Back-to-back frames: a falling rx_s at any cycle after the STOP evaluation starts a new frame.
//  No dead cycles are required.
//  A line held low continuously: the stop bit fails with STP_ERR, then a new START is detected.
//  Majority vote gives 1-sample glitch immunity inside any bit.
// TESTING
//  P=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 + parity 0 + stop -> P_DATA=0xA5, DATA_VALID pulse, no errors.
//  P=16, PAR_EN=0, frames 0x3C and 0xC3 sent back-to-back -> two DATA_VALID pulses: 0x3C, then 0xC3.
//  P=8, RX_IN low for 2 CLK then high -> START aborts, FSM returns to IDLE, no output pulses.
//  P=32, PAR_EN=1, PAR_TYP=1, frame 0x01 sent with parity 1 -> PAR_ERR pulse, DATA_VALID=0, P_DATA held.
//  P=8, PAR_EN=0, frame 0x55 with stop=0 -> STP_ERR pulse, DATA_VALID=0.
//  RST low during data bit 4 of 0xFF -> all outputs 0, no pulse; the next clean frame 0x12 is received correctly.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver.
// Frame is start, DATA_WIDTH data bits LSB-first, optional parity, stop.
// Each bit lasts PRESCALE clocks; the value is the majority of the three
// samples around the bit centre. Results are delivered as one-cycle pulses.
module uart_rx_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

  rx_state_t r_state;
  rx_state_t w_nextState;

  logic                  r_rxMeta;
  logic                  r_rxSync;
  logic [5:0]            r_prescale;
  logic                  r_parEn;
  logic                  r_parTyp;
  logic [5:0]            r_edgeCnt;
  logic [BW-1:0]         r_bitCnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_samp0;
  logic                  r_samp1;
  logic                  r_parFail;

  logic [5:0] w_half;
  logic       w_prescaleLegal;
  logic       w_sampEarly;
  logic       w_sampMid;
  logic       w_sampLate;
  logic       w_bitEnd;
  logic       w_vote;
  logic       w_startFrame;
  logic       w_lastBit;
  logic       w_expParity;
  logic       w_evalStop;
  logic       w_frameOk;
  logic       w_stopFail;
  logic       w_parReport;

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
    end else begin
      r_rxMeta <= RX_IN;
      r_rxSync <= r_rxMeta;
    end
  end

  assign w_prescaleLegal = (PRESCALE == 6'd8) || (PRESCALE == 6'd16) || (PRESCALE == 6'd32);
  assign w_half          = {1'b0, r_prescale[5:1]};
  assign w_sampEarly     = (r_edgeCnt == (w_half - 6'd1));
  assign w_sampMid       = (r_edgeCnt == w_half);
  assign w_sampLate      = (r_edgeCnt == (w_half + 6'd1));
  assign w_bitEnd        = (r_edgeCnt == (r_prescale - 6'd1));
  assign w_vote          = (r_samp0 & r_samp1) | (r_samp0 & r_rxSync) | (r_samp1 & r_rxSync);
  assign w_startFrame    = (r_state == S_IDLE) && !r_rxSync;
  assign w_lastBit       = (r_bitCnt == LAST_BIT);
  assign w_expParity     = (^r_shift) ^ r_parTyp;

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: bit boundaries come from the edge counter, the vote decides start and stop
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (!r_rxSync) w_nextState = S_START;
      end
      S_START: begin
        if (w_sampLate && w_vote) w_nextState = S_IDLE;
        else if (w_bitEnd) w_nextState = S_DATA;
      end
      S_DATA: begin
        if (w_bitEnd && w_lastBit) w_nextState = r_parEn ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_bitEnd) w_nextState = S_STOP;
      end
      S_STOP: begin
        if (w_sampLate) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Output decode: the stop-bit centre is the single point where a frame is judged
  always_comb begin
    w_evalStop  = 1'b0;
    w_frameOk   = 1'b0;
    w_stopFail  = 1'b0;
    w_parReport = 1'b0;
    if ((r_state == S_STOP) && w_sampLate) begin
      w_evalStop  = 1'b1;
      w_stopFail  = !w_vote;
      w_parReport = r_parFail;
      w_frameOk   = w_vote && !r_parFail;
    end
  end

  // Frame configuration is captured as the start bit is seen and held until the frame ends
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_prescale <= 6'd8;
      r_parEn    <= 1'b0;
      r_parTyp   <= 1'b0;
    end else if (w_startFrame) begin
      r_prescale <= w_prescaleLegal ? PRESCALE : 6'd8;
      r_parEn    <= PAR_EN;
      r_parTyp   <= PAR_TYP;
    end
  end

  // Edge and bit counters; both restart whenever the receiver leaves or sits in IDLE
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_edgeCnt <= '0;
      r_bitCnt  <= '0;
    end else begin
      if ((r_state == S_IDLE) || (w_nextState == S_IDLE) || w_bitEnd) r_edgeCnt <= '0;
      else r_edgeCnt <= r_edgeCnt + 6'd1;

      if (r_state != S_DATA) r_bitCnt <= '0;
      else if (w_bitEnd) r_bitCnt <= r_bitCnt + BW'(1);
    end
  end

  // Sampling, data shift and parity check; the third vote sample is the live synchronized line
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_samp0   <= 1'b1;
      r_samp1   <= 1'b1;
      r_shift   <= '0;
      r_parFail <= 1'b0;
    end else begin
      if (w_sampEarly) r_samp0 <= r_rxSync;
      if (w_sampMid) r_samp1 <= r_rxSync;
      if ((r_state == S_DATA) && w_sampLate) r_shift <= {w_vote, r_shift[DATA_WIDTH-1:1]};
      if (w_startFrame) r_parFail <= 1'b0;
      else if ((r_state == S_PARITY) && w_sampLate) r_parFail <= (w_vote != w_expParity);
    end
  end

  // Registered results; pulses last one cycle and P_DATA only moves on a clean frame
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= w_frameOk;
      PAR_ERR    <= w_parReport;
      STP_ERR    <= w_stopFail;
      if (w_evalStop && w_frameOk) P_DATA <= r_shift;
    end
  end

endmodule
